// File: rtl/lieat_sram_pkg.sv
// Shared definitions for the LIEAT SRAM request controller.
//
// Contents:
//   AW_DEF, DW_DEF  - default address / data widths (64 x 64-bit SRAM)
//   state_e         - controller state: INIT (power-up clearing sweep), RUN
//   rsp_entry_t     - layout of one response FIFO entry at the default width.
//                     The FIFO stores the same layout flattened as {wr, data},
//                     so wr is always the MSB.
package lieat_sram_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [DW_DEF-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/lieat_sram_rsp_fifo.sv
// Small synchronous FIFO that holds SRAM responses in request order.
//
// Parameters:
//   W      - entry width (response data plus the write flag)
//   DEPTH  - number of entries
// Ports:
//   clock  - clock
//   reset  - synchronous active-low reset; clears pointers and count
//   push   - write din (ignored when full)
//   din    - entry to store
//   pop    - drop the head entry (ignored when empty)
//   dout   - head entry; only meaningful while empty=0
//   full   - no free entry
//   empty  - no stored entry
//   count  - number of stored entries
module lieat_sram_rsp_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it unreset lets it map onto plain flops/RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lieat_sram_req_ctrl.sv
// Request/response front end for a single-port SRAM with combinational read.
//
// An accepted request drives the SRAM in the same cycle; the result (read
// data, or a zero-data write ack) is queued in a response FIFO and appears on
// the response port one cycle later at the earliest, in request order.
//
// Optional feature (macro LIEAT_SRAM_INIT_EN): after reset the controller
// sits in INIT and writes 0 to every SRAM address, one per cycle, before
// entering RUN. Without the macro the controller comes out of reset in RUN.
//
// Ports:
//   clock, reset             - clock, synchronous active-low reset
//   req_valid/req_ready      - request handshake
//   req_wr/req_addr/req_wdata- request: 1 = write, address, write data
//   rsp_valid/rsp_ready      - response handshake
//   rsp_wr/rsp_rdata         - response: write ack flag, read data (0 for acks)
//   init_done                - controller is in RUN
//   sram_CEn/sram_WEn        - SRAM chip enable (active low), write strobe
//   sram_A/sram_D/sram_Q     - SRAM address, write data, read data
module lieat_sram_req_ctrl
  import lieat_sram_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_wr,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic          sram_CEn,
  output logic          sram_WEn,
  output logic [AW-1:0] sram_A,
  output logic [DW-1:0] sram_D,
  input  logic [DW-1:0] sram_Q
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  state_e        state;
  logic          accept;
  logic          rsp_pop;
  logic [DW:0]   push_entry;
  logic [DW:0]   head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Ready depends only on state and FIFO occupancy, never on rsp_ready, so a
  // pop in the same cycle does not open a slot until the next cycle.
  assign req_ready = (state == RUN) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign init_done = (state == RUN);

  // Entry layout {wr, data}; writes carry zero data.
  assign push_entry = {req_wr, (req_wr ? {DW{1'b0}} : sram_Q)};

  assign rsp_valid = (fifo_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_wr    = !fifo_empty && head_entry[DW];
  assign rsp_rdata = fifo_empty ? '0 : head_entry[DW-1:0];

`ifdef LIEAT_SRAM_INIT_EN
  logic [AW-1:0] init_addr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= INIT;
      init_addr <= '0;
    end else if (state == INIT) begin
      // The last address is written in this cycle; RUN starts next cycle.
      if (init_addr == {AW{1'b1}}) state <= RUN;
      init_addr <= init_addr + 1'b1;
    end
  end
`else
  // NOTE: sequential state is assigned with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clock) begin
    if (!reset) state <= RUN;
  end
`endif

  // SRAM drive: idle values by default, the accepted request in RUN, the
  // clearing sweep in INIT. Every output gets its default first, so no latch.
  always_comb begin
    sram_CEn = 1'b1;
    sram_WEn = 1'b0;
    sram_A   = '0;
    sram_D   = '0;
    if (accept) begin
      sram_CEn = 1'b0;
      sram_WEn = req_wr;
      sram_A   = req_addr;
      sram_D   = req_wdata;
    end
`ifdef LIEAT_SRAM_INIT_EN
    if (state == INIT) begin
      sram_CEn = 1'b0;
      sram_WEn = 1'b1;
      sram_A   = init_addr;
      sram_D   = '0;
    end
`endif
  end

  lieat_sram_rsp_fifo #(
    .W     (DW + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .din   (push_entry),
    .pop   (rsp_pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_lieat_sram_req_ctrl.sv
// Directed bench for lieat_sram_req_ctrl with a behavioural 64 x 64 SRAM.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Build with LIEAT_SRAM_INIT_EN defined to exercise the INIT sweep.
module tb_lieat_sram_req_ctrl;

  localparam int AW = 6;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_wr;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_CEn;
  logic          sram_WEn;
  logic [AW-1:0] sram_A;
  logic [DW-1:0] sram_D;
  logic [DW-1:0] sram_Q;

  int vectors    = 0;
  int miscompares = 0;

  logic          fill = 1'b0;
  logic [DW-1:0] sram_mem [64];

  always #5 clock = ~clock;

  lieat_sram_req_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .sram_CEn  (sram_CEn),
    .sram_WEn  (sram_WEn),
    .sram_A    (sram_A),
    .sram_D    (sram_D),
    .sram_Q    (sram_Q)
  );

  function automatic logic [DW-1:0] pattern(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
  endfunction

  // SRAM model: combinational read, write at the clock edge; 'fill' loads
  // the known pattern into every address.
  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= pattern(i);
    end else if (!sram_CEn && sram_WEn) begin
      sram_mem[sram_A] <= sram_D;
    end
  end
  assign sram_Q = sram_mem[sram_A];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input int addr,
                       input logic [DW-1:0] data, input logic rdy);
    req_valid = v;
    req_wr    = wr;
    req_addr  = AW'(addr);
    req_wdata = data;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_fill();
    fill = 1'b1;
    step();
    fill = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp5;
    int            addr;

    reset = 1'b0;
    drive(0, 0, 0, '0, 0);
    @(negedge clock);
    do_fill();
    step();
    // ---- reset state ----
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_wr",    64'(rsp_wr),    64'd0);
    check("rst_rsp_rdata", rsp_rdata,      64'd0);

`ifdef LIEAT_SRAM_INIT_EN
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    // Start the sweep and reset it at address 20.
    reset = 1'b1;
    #1;
    for (int k = 0; k <= 20; k++) begin
      check("init1_a", 64'(sram_A), 64'(k));
      if (k < 20) step();
    end
    reset = 1'b0;
    step();
    check("midrst_a",         64'(sram_A),    64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_init_done", 64'(init_done), 64'd0);
    reset = 1'b1;
    #1;
    // Full sweep: {CEn, WEn, ready, init_done} = 4'b0100, A = k, D = 0.
    for (int k = 0; k < 64; k++) begin
      check("init_ctl", {60'd0, sram_CEn, sram_WEn, req_ready, init_done}, 64'b0100);
      check("init_a",   64'(sram_A), 64'(k));
      check("init_d",   sram_D, 64'd0);
      check("init_rsp_valid", 64'(rsp_valid), 64'd0);
      step();
      #1;
    end
    check("run_init_done", 64'(init_done), 64'd1);
    check("run_req_ready", 64'(req_ready), 64'd1);
    check("run_idle_cen",  64'(sram_CEn),  64'd1);
    exp5 = '0;
`else
    check("rst_idle_cen", 64'(sram_CEn), 64'd1);
    check("rst_idle_wen", 64'(sram_WEn), 64'd0);
    check("rst_idle_a",   64'(sram_A),   64'd0);
    check("rst_idle_d",   sram_D,        64'd0);
    reset = 1'b1;
    step();
    check("first_init_done", 64'(init_done), 64'd1);
    check("first_req_ready", 64'(req_ready), 64'd1);
    exp5 = pattern(5);
`endif
    @(negedge clock);

    // ---- read address 5 ----
    drive(1, 0, 5, '0, 1);
    check("rd5_ready", 64'(req_ready), 64'd1);
    check("rd5_cen",   64'(sram_CEn),  64'd0);
    check("rd5_wen",   64'(sram_WEn),  64'd0);
    check("rd5_a",     64'(sram_A),    64'd5);
    check("rd5_no_rsp_same_cycle", 64'(rsp_valid), 64'd0);
    step();
    drive(0, 0, 0, '0, 1);
    check("rd5_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd5_rsp_wr",    64'(rsp_wr),    64'd0);
    check("rd5_rdata",     rsp_rdata,      exp5);
    check("idle_cen", 64'(sram_CEn), 64'd1);
    check("idle_wen", 64'(sram_WEn), 64'd0);
    check("idle_a",   64'(sram_A),   64'd0);
    check("idle_d",   sram_D,        64'd0);
    step();
    #1;
    check("rd5_drained", 64'(rsp_valid), 64'd0);

    // ---- write 3 then read 3 in the next cycle ----
    drive(1, 1, 3, 64'hDEAD_BEEF_0123_4567, 1);
    check("wr3_wen", 64'(sram_WEn), 64'd1);
    check("wr3_a",   64'(sram_A),   64'd3);
    check("wr3_d",   sram_D,        64'hDEAD_BEEF_0123_4567);
    step();
    drive(1, 0, 3, '0, 1);
    check("rd3_wen",     64'(sram_WEn),  64'd0);
    check("wr3_ack_vld", 64'(rsp_valid), 64'd1);
    check("wr3_ack_wr",  64'(rsp_wr),    64'd1);
    check("wr3_ack_dat", rsp_rdata,      64'd0);
    step();
    drive(0, 0, 0, '0, 1);
    check("rd3_vld",   64'(rsp_valid), 64'd1);
    check("rd3_wr",    64'(rsp_wr),    64'd0);
    check("rd3_rdata", rsp_rdata,      64'hDEAD_BEEF_0123_4567);
    step();
    #1;
    check("rd3_drained", 64'(rsp_valid), 64'd0);

    do_fill();

    // ---- back-pressure: 3 reads offered with rsp_ready=0 ----
    drive(1, 0, 10, '0, 0);
    check("bp_a_ready", 64'(req_ready), 64'd1);
    step();
    drive(1, 0, 11, '0, 0);
    check("bp_b_ready", 64'(req_ready), 64'd1);
    check("bp_b_rdata", rsp_rdata, pattern(10));
    step();
    drive(1, 0, 12, '0, 0);
    check("bp_c_ready", 64'(req_ready), 64'd0);
    check("bp_c_valid", 64'(rsp_valid), 64'd1);
    check("bp_c_hold",  rsp_rdata, pattern(10));
    step();
    drive(1, 0, 12, '0, 1);
    check("bp_d_full_pop_ready", 64'(req_ready), 64'd0);
    check("bp_d_rdata", rsp_rdata, pattern(10));
    check("bp_d_cen",   64'(sram_CEn), 64'd1);
    step();
    drive(1, 0, 12, '0, 0);
    check("bp_e_ready", 64'(req_ready), 64'd1);
    check("bp_e_rdata", rsp_rdata, pattern(11));
    step();
    drive(0, 0, 0, '0, 0);
    check("bp_f_ready", 64'(req_ready), 64'd0);
    check("bp_f_rdata", rsp_rdata, pattern(11));
    step();
    drive(0, 0, 0, '0, 1);
    check("bp_g_rdata", rsp_rdata, pattern(11));
    step();
    check("bp_h_rdata", rsp_rdata, pattern(12));
    step();
    check("bp_drained", 64'(rsp_valid), 64'd0);

    // ---- streaming from a full FIFO with rsp_ready=1 ----
    drive(1, 0, 20, '0, 0);
    check("st_fill20", 64'(req_ready), 64'd1);
    step();
    drive(1, 0, 21, '0, 0);
    check("st_fill21", 64'(req_ready), 64'd1);
    step();
    for (int k = 0; k < 8; k++) begin
      addr = (k == 0) ? 22 : 21 + k;
      drive(1, 0, addr, '0, 1);
      check("st_ready", 64'(req_ready), (k == 0) ? 64'd0 : 64'd1);
      check("st_rdata", rsp_rdata, pattern(20 + k));
      step();
    end
    drive(0, 0, 0, '0, 1);
    check("st_last", rsp_rdata, pattern(28));
    step();
    check("st_drained", 64'(rsp_valid), 64'd0);

    // ---- reset discards a pending response ----
    drive(1, 0, 7, '0, 0);
    check("disc_ready", 64'(req_ready), 64'd1);
    step();
    drive(0, 0, 0, '0, 0);
    check("disc_pending", 64'(rsp_valid), 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("disc_rsp_valid", 64'(rsp_valid), 64'd0);
    check("disc_rsp_rdata", rsp_rdata,      64'd0);
`ifdef LIEAT_SRAM_INIT_EN
    check("disc_init_done", 64'(init_done), 64'd0);
    check("disc_sweep_a",   64'(sram_A),    64'd0);
`else
    check("disc_init_done", 64'(init_done), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lieat_sram_req_ctrl.md
LIEAT_SRAM_REQ_CTRL -- requirements
Module: lieat_sram_req_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- AW, 6, SRAM address width (64 entries)
- DW, 64, data width
- RSP_DEPTH, 2, response FIFO entries
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock, in, 1, single clock
- reset, in, 1, synchronous active-low reset
- req_valid, in, 1, request offered
- req_ready, out, 1, request accepted when valid&ready
- req_wr, in, 1, 1 = write, 0 = read
- req_addr, in, AW, entry address
- req_wdata, in, DW, write data
- rsp_valid, out, 1, response available
- rsp_ready, in, 1, response consumed when valid&ready
- rsp_wr, out, 1, response belongs to a write (ack)
- rsp_rdata, out, DW, read data; 0 for write acks
- init_done, out, 1, controller is in RUN
- sram_CEn, out, 1, active-low chip enable to SRAM
- sram_WEn, out, 1, active-high write strobe to SRAM
- sram_A, out, AW, SRAM address
- sram_D, out, DW, SRAM write data
- sram_Q, in, DW, SRAM read data, combinational on sram_A
REQ-003 Clock and reset SHALL be exactly as decided: one clock; reset is synchronous and active-low.

Function
REQ-004 The FSM SHALL have states INIT and RUN; reset enters INIT when LIEAT_SRAM_INIT_EN is defined, otherwise RUN.
REQ-005 req_ready SHALL be 1 only in RUN with the response FIFO not full; it SHALL NOT depend combinationally on rsp_ready.
REQ-006 On an accepted request in cycle N, the block SHALL drive sram_CEn=0, sram_A=req_addr, sram_WEn=req_wr, sram_D=req_wdata in cycle N, all combinationally from the request.
REQ-007 An accepted read SHALL push {wr=0, sram_Q} into the response FIFO at the end of cycle N; an accepted write SHALL push {wr=1, data=0}.
REQ-008 A response SHALL be visible on rsp_valid/rsp_wr/rsp_rdata in cycle N+1 at the earliest, with 1-cycle minimum latency, strictly in request order.
REQ-009 When idle, the block SHALL drive sram_CEn=1, sram_WEn=0, and hold sram_A and sram_D at 0.
REQ-010 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-011 If the FIFO is full and rsp_ready=1 in the same cycle, req_ready SHALL still be 0; the pop frees a slot for cycle N+1.
REQ-012 A simultaneous push and pop on a non-empty FIFO SHALL keep the occupancy unchanged.
REQ-013 Response outputs SHALL hold stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-014 While reset=0 at a clock edge, the block SHALL clear the FIFO pointers and count, the init counter and the state.
REQ-015 After reset, outputs SHALL be: rsp_valid=0, rsp_wr=0, rsp_rdata=0, req_ready=0 in INIT or 1 in RUN, init_done=0 in INIT or 1 in RUN, SRAM outputs in their idle values.
REQ-016 Reset during INIT SHALL restart the sweep at address 0; pending responses SHALL be discarded.

Configuration
REQ-017 When LIEAT_SRAM_INIT_EN is defined, INIT SHALL write 0 to addresses 0..2^AW-1, one per cycle, for 64 cycles with sram_CEn=0 and sram_WEn=1.
REQ-018 During INIT, req_ready and init_done SHALL be 0; after the write to the last address the block SHALL enter RUN and set init_done=1 in the next cycle.
REQ-019 When LIEAT_SRAM_INIT_EN is undefined, INIT logic SHALL be absent and init_done SHALL be 1 from the first cycle after reset.

Structure
REQ-020 A package lieat_sram_pkg SHALL hold the AW/DW defaults, the state enum {INIT, RUN} and the response entry struct {wr, data}.
REQ-021 The response FIFO SHALL be the sub-module lieat_sram_rsp_fifo (parameterised by DW+1 and RSP_DEPTH, with full/empty/count).

Verification
REQ-022 The bench SHALL cover these scenarios.
- INIT_EN defined, reset released: 64 cycles of WEn=1 over A=0..63 with D=0, then init_done=1; a read of addr 5 returns 0.
- Write addr 3 = 0xDEAD_BEEF_0123_4567, read addr 3 in the next cycle: responses are write ack (rsp_wr=1, rdata=0), then rdata=0xDEAD_BEEF_0123_4567.
- rsp_ready=0 with 3 reads offered: 2 accepted, req_ready=0; one rsp_ready pulse: exactly one more read accepted in the following cycle.
- Full FIFO with rsp_ready=1 and req_valid=1 every cycle: throughput of 1 per cycle after the first stall, order preserved.
- Reset asserted mid-INIT at address 20: sweep restarts at A=0, and rsp_valid stays 0.
- INIT_EN undefined: init_done=1 and req_ready=1 in the first cycle after reset.
